// File: rtl/packet_serializer.sv
// packet_serializer: captures a wide packet and streams it out one byte per ready cycle, LSB byte first.
// Define PKT_SERIALIZER_CHECKSUM_EN to append a trailing two's-complement checksum byte.
module packet_serializer #(
  parameter int pPacketSize = 244
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iPacketWr,
  input  logic [pPacketSize*8-1:0] iPacketData,
  output logic                     oPacketFull,
  output logic [7:0]               oByteData,
  output logic                     oByteValid,
  input  logic                     iByteReady,
  output logic                     oByteLast,
  output logic                     oErr
);

  localparam int         cBusW    = pPacketSize * 8;
  localparam logic [7:0] cLastIdx = 8'(pPacketSize - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
`ifdef PKT_SERIALIZER_CHECKSUM_EN
  localparam logic [1:0] CKSUM = 2'd2;
`endif
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [7:0]       byteCnt;
  logic [cBusW-1:0] shadow;
  logic             errFlag;
  logic             xfer;

`ifdef PKT_SERIALIZER_CHECKSUM_EN
  logic [7:0] cksumAcc;

  function automatic logic [7:0] cksumByte(input logic [7:0] sum);
    return 8'(9'h100 - {1'b0, sum});
  endfunction
`endif

  assign xfer = (state == SEND) && iByteReady;
  assign oErr = errFlag;

  // Control: state, byte counter, overrun flag and checksum accumulator
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      byteCnt <= '0;
      errFlag <= 1'b0;
`ifdef PKT_SERIALIZER_CHECKSUM_EN
      cksumAcc <= '0;
`endif
    end else begin
      if (iPacketWr && (state != IDLE)) errFlag <= 1'b1;
      case (state)
        IDLE: begin
          if (iPacketWr) begin
            state   <= SEND;
            byteCnt <= '0;
`ifdef PKT_SERIALIZER_CHECKSUM_EN
            cksumAcc <= '0;
`endif
          end
        end
        SEND: begin
          if (iByteReady) begin
            byteCnt <= byteCnt + 8'd1;
`ifdef PKT_SERIALIZER_CHECKSUM_EN
            cksumAcc <= cksumAcc + shadow[7:0];
            if (byteCnt == cLastIdx) state <= CKSUM;
`else
            if (byteCnt == cLastIdx) state <= DONE;
`endif
          end
        end
`ifdef PKT_SERIALIZER_CHECKSUM_EN
        CKSUM: begin
          if (iByteReady) state <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow is a shift register: the byte at index byteCnt always sits in the low lane
  always_ff @(posedge iClk) begin
    if ((state == IDLE) && iPacketWr) shadow <= iPacketData;
    else if (xfer)                    shadow <= {8'h00, shadow[cBusW-1:8]};
  end

  always_comb begin
    oPacketFull = (state != IDLE);
    oByteValid  = 1'b0;
    oByteData   = 8'h00;
    oByteLast   = 1'b0;
    case (state)
      SEND: begin
        oByteValid = 1'b1;
        oByteData  = shadow[7:0];
`ifndef PKT_SERIALIZER_CHECKSUM_EN
        oByteLast  = (byteCnt == cLastIdx);
`endif
      end
`ifdef PKT_SERIALIZER_CHECKSUM_EN
      CKSUM: begin
        oByteValid = 1'b1;
        oByteData  = cksumByte(cksumAcc);
        oByteLast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_packet_serializer.sv
// Bench for packet_serializer: vector table, hand sequences, random traffic against a queue model,
// and a full-size back-to-back run. Follows PKT_SERIALIZER_CHECKSUM_EN when defined.
module tb_packet_serializer;

  localparam int cNA = 4;
  localparam int cNB = 244;
`ifdef PKT_SERIALIZER_CHECKSUM_EN
  localparam int cCk = 1;
`else
  localparam int cCk = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstA, wrA, rdyA, fullA, validA, lastA, errA;
  logic [31:0]     dataA;
  logic [7:0]      byteA;
  logic            rstB, wrB, rdyB, fullB, validB, lastB, errB;
  logic [cNB*8-1:0] dataB;
  logic [7:0]      byteB;

  packet_serializer #(.pPacketSize(cNA)) dutA (
    .iClk(clk), .iRst(rstA), .iPacketWr(wrA), .iPacketData(dataA),
    .oPacketFull(fullA), .oByteData(byteA), .oByteValid(validA),
    .iByteReady(rdyA), .oByteLast(lastA), .oErr(errA)
  );

  packet_serializer #(.pPacketSize(cNB)) dutB (
    .iClk(clk), .iRst(rstB), .iPacketWr(wrB), .iPacketData(dataB),
    .oPacketFull(fullB), .oByteData(byteB), .oByteValid(validB),
    .iByteReady(rdyB), .oByteLast(lastB), .oErr(errB)
  );

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] data;
    logic        rdy;
    logic        eValid;
    logic [7:0]  eData;
    logic        eLast;
    logic        eFull;
    logic        eErr;
  } vec_t;
  vec_t vecs[$];

  logic [7:0] mq[$];
  bit         mDone;
  bit         mErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkA(input string pre, input logic v, input logic [7:0] d,
                        input logic l, input logic f, input logic e);
    check({pre, ".valid"}, 32'(validA), 32'(v));
    check({pre, ".data"},  32'(byteA),  32'(d));
    check({pre, ".last"},  32'(lastA),  32'(l));
    check({pre, ".full"},  32'(fullA),  32'(f));
    check({pre, ".err"},   32'(errA),   32'(e));
  endtask

  function automatic void addRow(input logic wr, input logic [31:0] data, input logic rdy,
                                 input logic v, input logic [7:0] d, input logic l,
                                 input logic f, input logic e);
    vec_t r;
    r.rst = 1'b0; r.wr = wr; r.data = data; r.rdy = rdy;
    r.eValid = v; r.eData = d; r.eLast = l; r.eFull = f; r.eErr = e;
    vecs.push_back(r);
  endfunction

  task automatic driveSample(input logic rst, input logic wr, input logic [31:0] data, input logic rdy);
    rstA = rst; wrA = wr; dataA = data; rdyA = rdy;
    @(negedge clk);
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic noCk;
    int bIdx;
    int bFrames;
    logic [7:0] hdr;
    noCk = (cCk == 0);

    // Two 4-byte frames: plain, then one hit by an overrun strobe while byte 1 is presented
    addRow(1'b1, 32'h44332211, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addRow(1'b0, 32'h0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    addRow(1'b0, 32'h0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    addRow(1'b0, 32'h0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    addRow(1'b0, 32'h0, 1'b1, 1'b1, 8'h44, noCk, 1'b1, 1'b0);
    if (cCk != 0) addRow(1'b0, 32'h0, 1'b1, 1'b1, 8'h56, 1'b1, 1'b1, 1'b0);
    addRow(1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    addRow(1'b1, 32'h44332211, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    addRow(1'b0, 32'h0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    addRow(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    addRow(1'b0, 32'h0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1);
    addRow(1'b0, 32'h0, 1'b1, 1'b1, 8'h44, noCk, 1'b1, 1'b1);
    if (cCk != 0) addRow(1'b0, 32'h0, 1'b1, 1'b1, 8'h56, 1'b1, 1'b1, 1'b1);
    addRow(1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    addRow(1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    rstA = 1'b1; wrA = 1'b0; dataA = '0; rdyA = 1'b0;
    rstB = 1'b1; wrB = 1'b0; dataB = '0; rdyB = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkA("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nextEdge();

    foreach (vecs[i]) begin
      driveSample(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].rdy);
      checkA($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eData, vecs[i].eLast,
             vecs[i].eFull, vecs[i].eErr);
      nextEdge();
    end

    // Reset mid-frame with a simultaneous strobe, then a clean restart
    driveSample(1'b0, 1'b1, 32'h44332211, 1'b1); nextEdge();
    driveSample(1'b0, 1'b0, 32'h0, 1'b1);
    check("mr.b0", 32'(byteA), 32'h11); nextEdge();
    driveSample(1'b0, 1'b0, 32'h0, 1'b1);
    check("mr.b1", 32'(byteA), 32'h22); nextEdge();
    driveSample(1'b1, 1'b1, 32'hDEADBEEF, 1'b1); nextEdge();
    driveSample(1'b0, 1'b0, 32'h0, 1'b1);
    checkA("mr.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); nextEdge();
    driveSample(1'b0, 1'b1, 32'hA1B2C3D4, 1'b1); nextEdge();
    driveSample(1'b0, 1'b0, 32'h0, 1'b0);
    checkA("mr.restart", 1'b1, 8'hD4, 1'b0, 1'b1, 1'b0); nextEdge();

    // Random traffic with long stall phases against a byte-queue model
    driveSample(1'b1, 1'b0, 32'h0, 1'b0); nextEdge();
    mq.delete(); mDone = 0; mErr = 0;
    for (int c = 0; c < 600; c++) begin
      bit mFull;
      bit lastX;
      logic [7:0] s;
      rstA  = ($urandom_range(0, 149) == 0);
      wrA   = ($urandom_range(0, 6) == 0);
      dataA = $urandom();
      rdyA  = (((c / 60) % 4) == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      mFull = (mq.size() != 0) || mDone;
      check("rnd.valid", 32'(validA), 32'(mq.size() != 0));
      check("rnd.data",  32'(byteA),  32'((mq.size() != 0) ? mq[0] : 8'h00));
      check("rnd.last",  32'(lastA),  32'(mq.size() == 1));
      check("rnd.full",  32'(fullA),  32'(mFull));
      check("rnd.err",   32'(errA),   32'(mErr));
      @(posedge clk);
      if (rstA) begin
        mq.delete(); mDone = 0; mErr = 0;
      end else begin
        lastX = (mq.size() == 1) && rdyA;
        if (wrA && mFull) mErr = 1;
        if ((mq.size() != 0) && rdyA) void'(mq.pop_front());
        mDone = lastX;
        if (wrA && !mFull) begin
          s = 8'h00;
          for (int k = 0; k < cNA; k++) begin
            mq.push_back(dataA[8*k +: 8]);
            s = s + dataA[8*k +: 8];
          end
          if (cCk != 0) mq.push_back(8'(9'h100 - {1'b0, s}));
        end
      end
      #1;
    end

    // Full-size frames strobed at the minimum spacing
    rstB = 1'b0; rdyB = 1'b1;
    bIdx = 0; bFrames = 0; hdr = 8'h00;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < cNB; k++) dataB[8*k +: 8] = 8'($urandom());
      hdr = dataB[7:0];
      for (int c = 0; c < cNB + 2 + cCk; c++) begin
        wrB = (c == 0);
        @(negedge clk);
        if (c == 0) check($sformatf("B.f%0d.ready", f), 32'(fullB), 32'h0);
        if (validB) begin
          if (bIdx == 0) check($sformatf("B.f%0d.hdr", f), 32'(byteB), 32'(hdr));
          bIdx++;
          if (lastB) begin
            check($sformatf("B.f%0d.len", f), 32'(bIdx), 32'(cNB + cCk));
            bIdx = 0;
            bFrames++;
          end
        end
        @(posedge clk);
        #1;
      end
      check($sformatf("B.f%0d.err", f), 32'(errB), 32'h0);
    end
    check("B.frames", 32'(bFrames), 32'd3);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
